// File: rtl/tmds_timing_ctrl.sv
// Video timing generator feeding three TMDS encoder channels.
// Produces the pixel request toward the source, registered DE, colour data
// and {vsync,hsync} for channel 0, and position and status outputs.
// A run/stop FSM ensures a frame that has started always completes.
module tmds_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        clr_status,
  output logic        pix_req,
  output logic        de,
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [1:0]  ctrl0,
  output logic [1:0]  ctrl1,
  output logic [1:0]  ctrl2,
  output logic [11:0] hcount,
  output logic [10:0] vcount,
  output logic        frame_start,
  output logic        busy,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STOPPING = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [11:0] h_cnt_r;
  logic [10:0] v_cnt_r;
  logic        running_s;
  logic        last_s;
  logic        hs_act_s;
  logic        vs_act_s;

  assign running_s = (state_r == ST_RUN) || (state_r == ST_STOPPING);
  assign last_s    = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
  assign hs_act_s  = running_s && (h_cnt_r >= HS_START) && (h_cnt_r <= HS_END);
  assign vs_act_s  = running_s && (v_cnt_r >= VS_START) && (v_cnt_r <= VS_END);

  // The source must answer in this same cycle, so the request stays combinational.
  assign pix_req = running_s && (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);

  // Channels 1 and 2 carry no control information.
  assign ctrl1 = 2'b00;
  assign ctrl2 = 2'b00;

  // FSM state register.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: stopping only takes effect on the last cycle of a frame.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_s = last_s ? ST_IDLE : ST_STOPPING;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STOPPING: begin
        if (last_s) begin
          state_s = enable ? ST_RUN : ST_IDLE;
        end else if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_STOPPING;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Raster counters: advance while running, held at zero while idle.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 11'd0;
    end else if (running_s) begin
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= 12'd0;
        v_cnt_r <= (v_cnt_r == V_LAST) ? 11'd0 : v_cnt_r + 11'd1;
      end else begin
        h_cnt_r <= h_cnt_r + 12'd1;
      end
    end else begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 11'd0;
    end
  end

  // Output pipeline stage: everything here lags the counters by one cycle.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      de          <= 1'b0;
      data0       <= 8'h00;
      data1       <= 8'h00;
      data2       <= 8'h00;
      ctrl0       <= {~VS_POL, ~HS_POL};
      hcount      <= 12'd0;
      vcount      <= 11'd0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      de <= pix_req;
      if (pix_req && pix_valid) begin
        data2 <= pix_data[23:16];
        data1 <= pix_data[15:8];
        data0 <= pix_data[7:0];
      end else begin
        data2 <= 8'h00;
        data1 <= 8'h00;
        data0 <= 8'h00;
      end
      ctrl0[1]    <= vs_act_s ? VS_POL : ~VS_POL;
      ctrl0[0]    <= hs_act_s ? HS_POL : ~HS_POL;
      hcount      <= running_s ? h_cnt_r : 12'd0;
      vcount      <= running_s ? v_cnt_r : 11'd0;
      frame_start <= running_s && (h_cnt_r == 12'd0) && (v_cnt_r == 11'd0);
      busy        <= running_s;
    end
  end

  // Sticky underflow: a missing pixel during a request wins over a clear.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (pix_req && !pix_valid) begin
      underflow <= 1'b1;
    end else if (clr_status) begin
      underflow <= 1'b0;
    end else begin
      underflow <= underflow;
    end
  end

endmodule

// File: tb/tb_tmds_timing_ctrl.sv
// Scoreboard bench for tmds_timing_ctrl with a reduced 8x6 raster.
module tb_tmds_timing_ctrl;

  logic        pixclk = 1'b0;
  logic        reset, enable, pix_valid, clr_status;
  logic [23:0] pix_data;
  logic        pix_req, de, frame_start, busy, underflow;
  logic [7:0]  data0, data1, data2;
  logic [1:0]  ctrl0, ctrl1, ctrl2;
  logic [11:0] hcount;
  logic [10:0] vcount;

  always #5 pixclk = ~pixclk;

  tmds_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixclk(pixclk), .reset(reset), .enable(enable), .pix_data(pix_data),
    .pix_valid(pix_valid), .clr_status(clr_status), .pix_req(pix_req),
    .de(de), .data0(data0), .data1(data1), .data2(data2),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
    .busy(busy), .underflow(underflow)
  );

  typedef struct {
    logic        de;
    logic [23:0] data;
    logic        hs;
    logic        vs;
    logic [11:0] hc;
    logic [10:0] vc;
    logic        fs;
    logic        busy;
    logic        uf;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  // reference model: 0 idle, 1 run, 2 stopping
  int   m_st = 0, mh = 0, mv = 0;
  logic m_uf = 1'b0;
  bit   model_known = 1'b0;

  int   tick_no = 0, since_rel = 0;
  int   first_req_idx = -1, first_de_idx = -1;
  bit   track_first = 1'b0;
  bit   hold_data = 1'b0;
  int   prev_fs = 0, de_cnt = 0;
  bit   have_prev = 1'b0;
  bit   count_busy = 1'b0;
  int   busy_seen = 0, fs_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One pixclk: predict, push, clock, pop and compare.
  task automatic tick();
    exp_t e, o;
    bit   run, req, last;
    if (!hold_data) pix_data = 24'($urandom);
    if (reset) since_rel = 0; else since_rel++;
    #1;
    run = model_known && (m_st != 0);
    req = run && (mh < 4) && (mv < 3);
    if (model_known) check_val("pix_req", {31'd0, pix_req}, {31'd0, req});
    if (track_first && !reset && pix_req === 1'b1 && first_req_idx < 0) first_req_idx = since_rel;

    if (reset) begin
      e = '{1'b0, 24'h0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0, 1'b0};
      m_st = 0; mh = 0; mv = 0; m_uf = 1'b0; model_known = 1'b1;
    end else begin
      e.de   = req;
      e.data = (req && pix_valid) ? pix_data : 24'h0;
      e.hs   = (run && (mh == 5 || mh == 6)) ? 1'b0 : 1'b1;
      e.vs   = (run && mv == 4) ? 1'b0 : 1'b1;
      e.hc   = run ? 12'(mh) : 12'd0;
      e.vc   = run ? 11'(mv) : 11'd0;
      e.fs   = run && mh == 0 && mv == 0;
      e.busy = run;
      if (req && !pix_valid) m_uf = 1'b1;
      else if (clr_status)   m_uf = 1'b0;
      e.uf   = m_uf;
      last   = (mh == 7) && (mv == 5);
      case (m_st)
        0: if (enable) m_st = 1;
        1: if (!enable) m_st = last ? 0 : 2;
        2: if (last) m_st = enable ? 1 : 0; else if (enable) m_st = 1;
        default: m_st = 0;
      endcase
      if (run) begin
        if (mh == 7) begin mh = 0; mv = (mv == 5) ? 0 : mv + 1; end
        else mh = mh + 1;
      end
    end
    sb_q.push_back(e);

    @(posedge pixclk);
    #1;
    tick_no++;
    o = sb_q.pop_front();
    check_val("de", {31'd0, de}, {31'd0, o.de});
    check_val("data2", {24'd0, data2}, {24'd0, o.data[23:16]});
    check_val("data1", {24'd0, data1}, {24'd0, o.data[15:8]});
    check_val("data0", {24'd0, data0}, {24'd0, o.data[7:0]});
    check_val("ctrl0", {30'd0, ctrl0}, {30'd0, o.vs, o.hs});
    check_val("ctrl1", {30'd0, ctrl1}, 32'd0);
    check_val("ctrl2", {30'd0, ctrl2}, 32'd0);
    check_val("hcount", {20'd0, hcount}, {20'd0, o.hc});
    check_val("vcount", {21'd0, vcount}, {21'd0, o.vc});
    check_val("frame_start", {31'd0, frame_start}, {31'd0, o.fs});
    check_val("busy", {31'd0, busy}, {31'd0, o.busy});
    check_val("underflow", {31'd0, underflow}, {31'd0, o.uf});

    if (track_first && de === 1'b1 && first_de_idx < 0) first_de_idx = since_rel;
    if (count_busy && busy === 1'b1) busy_seen++;
    if (busy !== 1'b1) have_prev = 1'b0;
    if (frame_start === 1'b1) begin
      fs_seen++;
      if (have_prev) begin
        check_val("fs_period", 32'(tick_no - prev_fs), 32'd48);
        check_val("de_per_frame", 32'(de_cnt), 32'd12);
      end
      prev_fs = tick_no; de_cnt = 0; have_prev = 1'b1;
    end
    if (de === 1'b1) de_cnt++;
  endtask

  // Advance until the model is running at pixel (h,v), bounded.
  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(m_st != 0 && mh == h && mv == v)) begin
      if (n >= 200) begin
        checks_cnt++; errors_cnt++;
        $display("FAIL wait_pos timeout h=%0d v=%0d", h, v);
        return;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; pix_valid = 1'b1; clr_status = 1'b0; pix_data = 24'h0;
    repeat (3) tick();

    // Start-up from reset with enable high; known colour on pixel (1,0).
    reset = 1'b0; track_first = 1'b1;
    wait_pos(1, 0);
    hold_data = 1'b1; pix_data = 24'hA1B2C3;
    tick();
    hold_data = 1'b0;
    check_val("rgb_d2", {24'd0, data2}, 32'h0000_00A1);
    check_val("rgb_d1", {24'd0, data1}, 32'h0000_00B2);
    check_val("rgb_d0", {24'd0, data0}, 32'h0000_00C3);
    track_first = 1'b0;
    check_val("first_req_idx", 32'(first_req_idx), 32'd2);
    check_val("first_de_idx", 32'(first_de_idx), 32'd2);

    // Underflow set, set-vs-clear collision, then a lone clear.
    wait_pos(2, 1);
    pix_valid = 1'b0; tick(); pix_valid = 1'b1;
    repeat (3) tick();
    wait_pos(1, 2);
    pix_valid = 1'b0; clr_status = 1'b1; tick();
    pix_valid = 1'b1; tick();
    clr_status = 1'b0;
    repeat (100) tick();

    // Enable dropped mid-frame: frame runs out from (1,1) to (7,5).
    wait_pos(1, 1);
    enable = 1'b0; busy_seen = 0; count_busy = 1'b1;
    repeat (50) tick();
    count_busy = 1'b0;
    check_val("stop_len", 32'(busy_seen), 32'd39);

    // Drop and re-raise inside one frame: no gap between frames.
    enable = 1'b1;
    wait_pos(2, 1);
    enable = 1'b0;
    wait_pos(4, 3);
    enable = 1'b1;
    repeat (60) tick();

    // Reset in the middle of pixel (3,2), enable left high.
    wait_pos(3, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("rst_de", {31'd0, de}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    fs_seen = 0;
    repeat (60) tick();
    check_val("restart_fs", 32'(fs_seen), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/tmds_timing_ctrl.md
TMDS_TIMING_CTRL -- requirements
Module: tmds_timing_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixclk cycles)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

REQ-002 Ports, one per line: name, direction, width, meaning.
- pixclk, in, 1, pixel clock; sole clock
- reset, in, 1, synchronous active-high reset
- enable, in, 1, run request; sampled each pixclk
- pix_data, in, 24, {R[23:16],G[15:8],B[7:0]} from pixel source
- pix_valid, in, 1, pix_data valid this cycle
- clr_status, in, 1, clears underflow
- pix_req, out, 1, pixel request (ready); source must present pix_data/pix_valid in the same cycle
- de, out, 1, to all three tmds_encoder DE inputs
- data0/data1/data2, out, 8 each, B/G/R to encoder channels 0/1/2
- ctrl0, out, 2, {vsync,hsync} to channel 0
- ctrl1/ctrl2, out, 2 each, constant 2'b00
- hcount, out, 12, horizontal position of current output
- vcount, out, 11, vertical position of current output
- frame_start, out, 1, one-cycle pulse with output pixel (0,0)
- busy, out, 1, high while running
- underflow, out, 1, sticky underflow flag

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 The internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) SHALL advance only while running: h_cnt increments each cycle, wraps to 0 at H_TOTAL-1; v_cnt increments on h wrap, wraps to 0 at V_TOTAL-1.
REQ-005 Region order per axis SHALL be active, front porch, sync, back porch, starting at count 0.
REQ-006 pix_req SHALL be combinational: running AND h_cnt<H_ACTIVE AND v_cnt<V_ACTIVE.
REQ-007 All outputs except pix_req SHALL be registered, with one pixclk of latency from the counter state.
REQ-008 de SHALL equal the delayed pix_req.
REQ-009 hsync SHALL be at HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else at ~HS_POL.
REQ-010 vsync SHALL be at VS_POL for every h_cnt when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else at ~VS_POL.
REQ-011 When pix_req=1 and pix_valid=1, data2/1/0 SHALL register pix_data[23:16]/[15:8]/[7:0].
REQ-012 When pix_req=1 and pix_valid=0, data outputs SHALL register 8'h00 and underflow SHALL be set.
REQ-013 When pix_req=0, data outputs SHALL register 8'h00, and pix_valid SHALL be ignored.
REQ-014 underflow SHALL clear on clr_status; when set and clear occur in the same cycle, set wins.
REQ-015 Control FSM states:
- IDLE -> RUN when enable=1, with counters at 0.
- RUN -> STOPPING when enable=0.
- STOPPING -> RUN when enable returns to 1 before the frame ends.
- STOPPING -> IDLE at the last frame cycle (h=H_TOTAL-1, v=V_TOTAL-1), with counters wrapped to 0.
- Frames SHALL never be truncated by enable.
REQ-016 running = (RUN or STOPPING). busy SHALL be the registered running signal.
REQ-017 In IDLE, the outputs SHALL be:
- de=0, data=0
- hsync=~HS_POL, vsync=~VS_POL
- hcount=vcount=0, frame_start=0
- counters frozen at 0
REQ-018 frame_start SHALL be 1 exactly in the output cycle whose hcount=0 and vcount=0 while busy.
REQ-019 hcount/vcount SHALL be the zero-extended delayed h_cnt/v_cnt.

Reset
REQ-020 Reset SHALL set the FSM to IDLE, h_cnt=v_cnt=0 and underflow=0, with all outputs as in REQ-017; reset overrides all other inputs.
REQ-021 Reset asserted mid-frame SHALL abort the frame in the next cycle with no completion.

Verification (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=VS_POL=0; H_TOTAL=8, V_TOTAL=6)
REQ-022 Reset released with enable=1 and pix_valid=1 -> pix_req high from the 2nd cycle, de high the cycle after, frame_start coincident with the first de, 4 de cycles per line, frame period 48 cycles.
REQ-023 One line -> hsync=0 exactly at hcount 5..6; vsync=0 for all 8 cycles of vcount 4; ctrl0={vsync,hsync}; ctrl1=ctrl2=0.
REQ-024 pix_data=24'hA1B2C3 on the active pixel -> data2=A1, data1=B2, data0=C3 one cycle later with de=1.
REQ-025 pix_valid=0 at pixel (2,1) -> data0..2=00 for that pixel; underflow set and held; clr_status on the same cycle as a new underflow -> stays 1; clr_status alone -> 0 next cycle.
REQ-026 enable dropped mid-frame -> frame completes to (7,5), then busy=0 with idle outputs; enable dropped and re-raised within the frame -> continuous frames, no gap.
REQ-027 reset pulsed at pixel (3,2) -> next cycle de=0, syncs inactive, busy=0; with enable still high, restart at (0,0) with frame_start.
